// File: rtl/shift_register_universal.sv
// Universal LENGTH-bit shift register (hold / shift up / shift down / load) with J/K entry
// and an auto-serialise sequencer. Optional rotate: define SHIFT_REGISTER_ROTATE_EN.
module shift_register_universal #(
    parameter int unsigned LENGTH = 4,
    parameter int unsigned CW     = $clog2(LENGTH + 1)
) (
    input  logic              CP,
    input  logic              MR,
    input  logic [LENGTH-1:0] P,
    input  logic [1:0]        S,
    input  logic              J,
    input  logic              K,
    input  logic              DSL,
`ifdef SHIFT_REGISTER_ROTATE_EN
    input  logic              ROT,
`endif
    input  logic              START,
    output logic [LENGTH-1:0] Q,
    output logic              QNnot,
    output logic              SO,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [LENGTH-1:0] q_nx;
    logic [LENGTH-1:0] q_up_c, q_dn_c;
    logic              busy_nx, done_nx;
    logic              jk_c, rot_c;

`ifdef SHIFT_REGISTER_ROTATE_EN
    assign rot_c = ROT;
`else
    assign rot_c = 1'b0;
`endif

    // Stage-0 entry; K is active-low so J=0,K=1 holds and J=1,K=0 toggles
    always_comb begin
        jk_c = Q[0];
        case ({J, K})
            2'b00:   jk_c = 1'b0;
            2'b11:   jk_c = 1'b1;
            2'b10:   jk_c = ~Q[0];
            default: jk_c = Q[0];
        endcase
    end

    assign q_up_c = {Q[LENGTH-2:0], (rot_c ? Q[LENGTH-1] : jk_c)};
    assign q_dn_c = {(rot_c ? Q[0] : DSL), Q[LENGTH-1:1]};

    always_comb begin
        state_nx = state;
        q_nx     = Q;
        cnt_nx   = cnt;
        busy_nx  = BUSY;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    q_nx     = P;
                    cnt_nx   = CW'(LENGTH);
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    case (S)
                        2'b01:   q_nx = q_up_c;
                        2'b10:   q_nx = q_dn_c;
                        2'b11:   q_nx = P;
                        default: q_nx = Q;
                    endcase
                end
            end
            SHIFT: begin
                q_nx   = q_up_c;
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state <= IDLE;
            Q     <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nx;
            Q     <= q_nx;
            cnt   <= cnt_nx;
            BUSY  <= busy_nx;
            DONE  <= done_nx;
        end
    end

    assign QNnot = ~Q[LENGTH-1];
    assign SO    = Q[LENGTH-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed and randomized bench for shift_register_universal (LENGTH=4) against an
// arithmetic reference model; ROT checks are included when SHIFT_REGISTER_ROTATE_EN is set.
module tb_shift_register_universal;

    localparam int unsigned L    = 4;
    localparam int unsigned MASK = (1 << L) - 1;

    logic         cp = 1'b0;
    logic         mr = 1'b1;
    logic [L-1:0] p = '0;
    logic [1:0]   s = 2'b00;
    logic         j = 1'b0, k = 1'b0, dsl = 1'b0, start = 1'b0, rot = 1'b0;
    logic [L-1:0] q;
    logic         qnnot, so, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int mq = 0;
    int mleft = 0;
    bit mbusy = 0;
    bit mdone = 0;

    shift_register_universal #(.LENGTH(L)) dut (
        .CP(cp), .MR(mr), .P(p), .S(s), .J(j), .K(k), .DSL(dsl),
`ifdef SHIFT_REGISTER_ROTATE_EN
        .ROT(rot),
`endif
        .START(start), .Q(q), .QNnot(qnnot), .SO(so), .BUSY(busy), .DONE(done)
    );

    always #5 cp = ~cp;

    function automatic int up_val(int v, bit jj, bit kk, bit rr);
        int b0 = v & 1;
        int top = (v >> (L - 1)) & 1;
        int e = rr ? top : ((jj & ~b0) | (~kk & 1 & 0) | (kk & b0) | (jj & kk)) & 1;
        return ((v << 1) | e) & MASK;
    endfunction

    function automatic int dn_val(int v, bit d, bit rr);
        int e = rr ? (v & 1) : int'(d);
        return (v >> 1) | (e << (L - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".Q"}, 32'(q), 32'(mq));
        chk({tag, ".QNnot"}, 32'(qnnot), 32'(((mq >> (L - 1)) & 1) ^ 1));
        chk({tag, ".SO"}, 32'(so), 32'((mq >> (L - 1)) & 1));
        chk({tag, ".BUSY"}, 32'(busy), 32'(mbusy));
        chk({tag, ".DONE"}, 32'(done), 32'(mdone));
    endtask

    task automatic model_reset();
        mq = 0; mleft = 0; mbusy = 0; mdone = 0;
    endtask

    // Advance model with current inputs, clock once, compare away from the edge
    task automatic tick(input string tag);
        if (mleft > 0) begin
            mq = up_val(mq, j, k, rot);
            mleft--;
            mdone = (mleft == 0);
            mbusy = (mleft != 0);
        end else begin
            mdone = 0;
            if (start) begin
                mq = int'(p); mleft = L; mbusy = 1;
            end else begin
                case (s)
                    2'b01: mq = up_val(mq, j, k, rot);
                    2'b10: mq = dn_val(mq, dsl, rot);
                    2'b11: mq = int'(p);
                    default: ;
                endcase
            end
        end
        @(posedge cp);
        #1;
        chk_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 mr = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        #1 mr = 1'b0;
    endtask

    logic [3:0] so_seq;

    initial begin
        #12;
        chk_all("reset_hold");
        mr = 1'b0;
        @(posedge cp); #1;

        // Async reset with Q=1010, no clock edge
        s = 2'b11; p = 4'b1010; tick("load1010");
        chk("q_1010", 32'(q), 32'hA);
        s = 2'b00;
        async_reset("async_mr");
        chk("q_after_mr", 32'(q), 32'h0);

        // J/K table
        s = 2'b01;
        j = 1; k = 1; tick("jk11"); chk("jk11_lit", 32'(q), 32'b0001);
        j = 1; k = 0; tick("jk10"); chk("jk10_lit", 32'(q), 32'b0010);
        j = 0; k = 1; tick("jk01"); chk("jk01_lit", 32'(q), 32'b0100);
        j = 0; k = 0; tick("jk00"); chk("jk00_lit", 32'(q), 32'b1000);

        // Mode sweep
        s = 2'b11; p = 4'b1011; tick("ld1011"); chk("ld_lit", 32'(q), 32'b1011);
        s = 2'b10; dsl = 0; tick("dn0"); chk("dn0_lit", 32'(q), 32'b0101);
        s = 2'b00;
        for (int i = 0; i < 3; i++) tick("hold");
        chk("hold_lit", 32'(q), 32'b0101);
        s = 2'b10; dsl = 1; tick("dn1"); chk("dn1_lit", 32'(q), 32'b1010);
        chk("dn1_qn", 32'(qnnot), 32'h0);

        // Auto-serialise, S toggled while busy
        s = 2'b00; j = 0; k = 0; p = 4'b1101; start = 1;
        tick("as_load");
        so_seq[3] = so;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            s = 2'($urandom_range(0, 3));
            p = 4'($urandom);
            tick("as_shift");
            so_seq[2 - i] = so;
        end
        chk("as_so_seq", 32'(so_seq), 32'b1101);
        tick("as_last");
        chk("as_final_q", 32'(q), 32'h0);
        chk("as_done", 32'(done), 32'h1);
        chk("as_busy_off", 32'(busy), 32'h0);
        s = 2'b00;
        tick("as_done_drop");
        chk("as_done_1cyc", 32'(done), 32'h0);

        // Abort mid-sequence then restart
        p = 4'b1101; start = 1; tick("ab_load");
        start = 0; tick("ab_s1"); tick("ab_s2");
        async_reset("ab_mr");
        for (int i = 0; i < 4; i++) tick("ab_nodone");
        p = 4'b0110; start = 1; tick("rs_load");
        start = 0;
        for (int i = 0; i < 3; i++) tick("rs_shift");
        tick("rs_last");
        chk("rs_done", 32'(done), 32'h1);

        // START held: back-to-back with one DONE cycle gap
        start = 1; p = 4'b1001; j = 1; k = 0;
        for (int i = 0; i < 12; i++) tick("b2b");
        start = 0;
        for (int i = 0; i < 5; i++) tick("b2b_drain");

`ifdef SHIFT_REGISTER_ROTATE_EN
        rot = 1; p = 4'b1010; start = 1; tick("rot_load");
        start = 0;
        for (int i = 0; i < 4; i++) tick("rot_shift");
        chk("rot_nondestr", 32'(q), 32'hA);
        s = 2'b11; p = 4'b1001; tick("rot_ld");
        s = 2'b01; tick("rot_up"); chk("rot_up_lit", 32'(q), 32'b0011);
        s = 2'b10; tick("rot_dn"); chk("rot_dn_lit", 32'(q), 32'b1001);
        rot = 0;
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = 2'($urandom);
            p = 4'($urandom);
            j = 1'($urandom);
            k = 1'($urandom);
            dsl = 1'($urandom);
            start = ($urandom_range(0, 7) == 0);
`ifdef SHIFT_REGISTER_ROTATE_EN
            rot = 1'($urandom);
`endif
            if ($urandom_range(0, 63) == 0) async_reset("rnd_mr");
            else tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
